// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch front end: FSM state encoding,
// PC step, instruction width and the packed {pc, inst} buffer entry.
// -----------------------------------------------------------------------------
package fetch_pkg;

  localparam int          INST_W  = 32;
  localparam logic [31:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_t;

  // One buffered instruction together with the address it was fetched from.
  typedef struct packed {
    logic [31:0]       pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Synchronous DEPTH-entry FIFO holding fetched {pc, inst} words.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   i_push    : write i_wdata (ignored when full or clearing)
//   i_pop     : drop the head entry (ignored when empty or clearing)
//   i_clear   : empty the FIFO, takes priority over push/pop
//   i_wdata   : entry to write
//   o_rdata   : head entry (content is stale when o_count == 0)
//   o_count   : number of valid entries, 0..DEPTH
// -----------------------------------------------------------------------------
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_clear,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic [CNT_W-1:0] o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_full;
  logic w_empty;
  logic w_do_push;
  logic w_do_pop;

  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_do_push = i_push && !w_full  && !i_clear;
  assign w_do_pop  = i_pop  && !w_empty && !i_clear;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    end
  end

  // NOTE: the storage array has no reset; only pointers and count do. Entries
  // are never observed before being written, and the top gates outputs on count.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch front end. Owns the PC, issues in-order word reads to
// instruction memory, buffers returned words with their PC and presents
// {inst, pc, pc+4} to decode. A redirect from execute flushes the buffer and
// discards every response still owed for wrong-path requests.
//
// Optional feature (macro FETCH_MISALIGN_TRAP_EN):
//   defined   : a redirect to a non-word-aligned address flushes, parks the PC
//               at the target, stops requesting and raises sticky
//               misalign_fault until an aligned redirect or reset.
//   undefined : redirect_addr[1:0] is forced to 2'b00; no misalign_fault port.
//
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   imem_req_valid/ready     : request handshake, imem_req_addr = current PC
//   imem_rsp_valid/data      : in-order read data, no backpressure
//   redirect_valid/addr      : taken branch/jump target from execute
//   inst_valid/ready         : decode handshake
//   inst_out, pc_out, pc_4_out : head instruction, its PC and PC+4
//   misalign_fault           : sticky misaligned-target flag (macro only)
// -----------------------------------------------------------------------------
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4,
  parameter int          CNT_W    = 3
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_addr,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_out,
  output logic [31:0] pc_out,
  output logic [31:0] pc_4_out
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        misalign_fault
`endif
);

  localparam logic [CNT_W:0] DEPTH_L = (CNT_W + 1)'(DEPTH);

  fetch_state_t     r_state;
  fetch_state_t     w_state_next;
  logic [31:0]      r_pc;
  logic [31:0]      r_rsp_pc;     // PC of the next response that will be kept
  logic [CNT_W-1:0] r_inflight;   // accepted requests whose data has not returned
  logic [CNT_W-1:0] r_drop;       // of those, how many belong to a flushed path

  logic [CNT_W-1:0] w_inflight_next;
  logic [CNT_W-1:0] w_drop_next;
  logic [CNT_W-1:0] w_count;
  logic [CNT_W:0]   w_occupancy;
  logic [31:0]      w_target;
  logic             w_accept;
  logic             w_push;
  logic             w_pop;
  logic             w_fault;
  fetch_entry_t     w_wr_entry;
  fetch_entry_t     w_rd_entry;

  // ---------------------------------------------------------------------------
  // Redirect target and optional misalignment trap
  // ---------------------------------------------------------------------------
`ifdef FETCH_MISALIGN_TRAP_EN
  logic r_fault;

  assign w_target = redirect_addr;

  // Every redirect re-evaluates the flag, so an aligned one clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 r_fault <= 1'b0;
    else if (redirect_valid) r_fault <= (redirect_addr[1:0] != 2'b00);
  end

  assign w_fault        = r_fault;
  assign misalign_fault = r_fault;
`else
  logic w_unused_addr_lsb;

  assign w_target          = {redirect_addr[31:2], 2'b00};
  assign w_fault           = 1'b0;
  assign w_unused_addr_lsb = ^redirect_addr[1:0];
`endif

  // ---------------------------------------------------------------------------
  // Credit check: buffered words plus outstanding requests never exceed DEPTH,
  // so every response is guaranteed a free buffer slot.
  // ---------------------------------------------------------------------------
  assign w_occupancy    = {1'b0, w_count} + {1'b0, r_inflight};
  assign imem_req_valid = (r_state != ST_BOOT) && (w_occupancy < DEPTH_L) && !w_fault;
  assign imem_req_addr  = r_pc;
  assign w_accept       = imem_req_valid && imem_req_ready;

  assign w_inflight_next = r_inflight + CNT_W'(w_accept) - CNT_W'(imem_rsp_valid);

  // A redirect marks everything still owed after this cycle as wrong-path,
  // including a request accepted in the same cycle.
  always_comb begin
    w_drop_next = r_drop;
    if (redirect_valid)                       w_drop_next = w_inflight_next;
    else if (imem_rsp_valid && r_drop != '0)  w_drop_next = r_drop - CNT_W'(1);
  end

  // Responses arriving during a redirect are wrong-path as well.
  assign w_push = imem_rsp_valid && (r_drop == '0) && !redirect_valid;
  assign w_pop  = inst_valid && inst_ready && !redirect_valid;

  // ---------------------------------------------------------------------------
  // FSM: BOOT idles one cycle; RUN and DRAIN both fetch, DRAIN while wrong-path
  // responses are still owed.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default first so no path through the case leaves a latch.
    w_state_next = r_state;
    unique case (r_state)
      ST_BOOT:            w_state_next = ST_RUN;
      ST_RUN, ST_DRAIN:   w_state_next = (w_drop_next != '0) ? ST_DRAIN : ST_RUN;
      default:            w_state_next = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_BOOT;
      r_pc       <= RESET_PC;
      r_rsp_pc   <= RESET_PC;
      r_inflight <= '0;
      r_drop     <= '0;
    end else begin
      r_state    <= w_state_next;
      r_inflight <= w_inflight_next;
      r_drop     <= w_drop_next;

      if (redirect_valid)  r_pc <= w_target;
      else if (w_accept)   r_pc <= r_pc + PC_STEP;

      // The first kept response after a redirect is the target's fetch.
      if (redirect_valid)  r_rsp_pc <= w_target;
      else if (w_push)     r_rsp_pc <= r_rsp_pc + PC_STEP;
    end
  end

  // ---------------------------------------------------------------------------
  // Instruction buffer
  // ---------------------------------------------------------------------------
  assign w_wr_entry.pc   = r_rsp_pc;
  assign w_wr_entry.inst = imem_rsp_data;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clear (redirect_valid),
    .i_wdata (w_wr_entry),
    .o_rdata (w_rd_entry),
    .o_count (w_count)
  );

  // Outputs are forced to zero while the buffer is empty so stale storage
  // never leaks to decode.
  assign inst_valid = (w_count != '0);
  assign inst_out   = inst_valid ? w_rd_entry.inst          : '0;
  assign pc_out     = inst_valid ? w_rd_entry.pc            : '0;
  assign pc_4_out   = inst_valid ? w_rd_entry.pc + PC_STEP  : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Directed bench for fetch_unit. A small instruction-memory responder returns
// {addr[15:0], 16'h0013} for each accepted request after a configurable
// latency; expected values below are written out by hand.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_addr  = 32'h0;
  logic        inst_valid;
  logic        inst_ready = 1'b1;
  logic [31:0] inst_out;
  logic [31:0] pc_out;
  logic [31:0] pc_4_out;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        misalign_fault;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int lat     = 1;

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_out       (inst_out),
    .pc_out         (pc_out),
    .pc_4_out       (pc_4_out)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .misalign_fault (misalign_fault)
`endif
  );

  always #5 clk = ~clk;

  // Instruction memory responder: fixed-latency pipeline, stage 0 drives data.
  logic [3:0]  pv;
  logic [31:0] pa [4];

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], 16'h0013};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pv <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        pv[i] <= pv[i+1];
        pa[i] <= pa[i+1];
      end
      pv[3] <= 1'b0;
      if (imem_req_valid && imem_req_ready) begin
        pv[lat-1] <= 1'b1;
        pa[lat-1] <= imem_req_addr;
      end
    end
  end

  assign imem_rsp_valid = pv[0];
  assign imem_rsp_data  = word_of(pa[0]);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns one cycle after reset release: the DUT is in BOOT.
  task automatic do_reset();
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int k = 0;
    while (!inst_valid && k < 20) begin
      tick();
      k++;
    end
    check(tag, {31'b0, inst_valid}, 32'h1);
  endtask

  task automatic redirect_to(input logic [31:0] a);
    redirect_valid = 1'b1;
    redirect_addr  = a;
    tick();
    redirect_valid = 1'b0;
  endtask

  initial begin
    int n_acc;
    @(negedge clk);

    // ---- 1: reset state, first request, streaming -------------------------
    lat = 1;
    do_reset();
    check("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
    check("rst_req_addr",  imem_req_addr,            32'h0);
    check("rst_inst_valid",{31'b0, inst_valid},     32'h0);
    check("rst_inst_out",  inst_out,                 32'h0);
    check("rst_pc_out",    pc_out,                   32'h0);
    check("rst_pc_4_out",  pc_4_out,                 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
    check("rst_fault",     {31'b0, misalign_fault}, 32'h0);
`endif
    tick();
    check("t1_req_valid",  {31'b0, imem_req_valid}, 32'h1);
    check("t1_req_addr0",  imem_req_addr,            32'h0);
    tick();
    check("t1_req_addr4",  imem_req_addr,            32'h4);
    check("t1_no_bypass",  {31'b0, inst_valid},     32'h0);
    tick();
    check("t1_v0",         {31'b0, inst_valid},     32'h1);
    check("t1_inst0",      inst_out,                 32'h0000_0013);
    check("t1_pc0",        pc_out,                   32'h0);
    check("t1_pc4_0",      pc_4_out,                 32'h4);
    tick();
    check("t1_inst4",      inst_out,                 32'h0004_0013);
    check("t1_pc4",        pc_out,                   32'h4);
    tick();
    check("t1_inst8",      inst_out,                 32'h0008_0013);
    check("t1_pc8",        pc_out,                   32'h8);

    // ---- 2: decode stalled, credit limit -----------------------------------
    do_reset();
    inst_ready = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 10; i++) begin
      if (imem_req_valid && imem_req_ready) n_acc++;
      tick();
    end
    check("t2_accepts",    n_acc,                    32'd4);
    check("t2_req_low",    {31'b0, imem_req_valid}, 32'h0);
    inst_ready = 1'b1;
    check("t2_pc_0",       pc_out,                   32'h0);
    check("t2_inst_0",     inst_out,                 32'h0000_0013);
    tick();
    check("t2_pc_4",       pc_out,                   32'h4);
    tick();
    check("t2_pc_8",       pc_out,                   32'h8);
    tick();
    check("t2_pc_c",       pc_out,                   32'hC);
    check("t2_inst_c",     inst_out,                 32'h000C_0013);

    // ---- 3: imem not ready, request held -----------------------------------
    do_reset();
    imem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t3_hold_valid", {31'b0, imem_req_valid}, 32'h1);
      check("t3_hold_addr",  imem_req_addr,            32'h0);
    end
    check("t3_no_inst",    {31'b0, inst_valid},     32'h0);
    imem_req_ready = 1'b1;
    tick();
    check("t3_advance",    imem_req_addr,            32'h4);
    wait_valid("t3_wait");
    check("t3_pc0",        pc_out,                   32'h0);

    // ---- 4: redirect with two requests outstanding (latency 2) -------------
    lat = 2;
    do_reset();
    tick();
    tick();
    check("t4_pre_addr",   imem_req_addr,            32'h4);
    redirect_to(32'h100);
    check("t4_new_addr",   imem_req_addr,            32'h100);
    check("t4_flushed",    {31'b0, inst_valid},     32'h0);
    wait_valid("t4_wait");
    check("t4_pc",         pc_out,                   32'h100);
    check("t4_pc_4",       pc_4_out,                 32'h104);
    check("t4_inst",       inst_out,                 32'h0100_0013);
    tick();
    check("t4_pc_next",    pc_out,                   32'h104);
    lat = 1;

    // ---- 5: redirect coinciding with response and pop ----------------------
    do_reset();
    tick();
    tick();
    tick();
    check("t5_pre_valid",  {31'b0, inst_valid},     32'h1);
    check("t5_pre_pc",     pc_out,                   32'h0);
    redirect_to(32'h200);
    check("t5_empty",      {31'b0, inst_valid},     32'h0);
    check("t5_new_addr",   imem_req_addr,            32'h200);
    wait_valid("t5_wait");
    check("t5_pc",         pc_out,                   32'h200);
    check("t5_inst",       inst_out,                 32'h0200_0013);

    // ---- 6: PC wrap at top of address space --------------------------------
    do_reset();
    tick();
    redirect_to(32'hFFFF_FFFC);
    check("t6_top_addr",   imem_req_addr,            32'hFFFF_FFFC);
    tick();
    check("t6_wrap_addr",  imem_req_addr,            32'h0);
    wait_valid("t6_wait");
    check("t6_pc",         pc_out,                   32'hFFFF_FFFC);
    check("t6_pc_4",       pc_4_out,                 32'h0);
    check("t6_inst",       inst_out,                 32'hFFFC_0013);

    // ---- 7: redirect while in BOOT -----------------------------------------
    do_reset();
    redirect_to(32'h40);
    check("t7_boot_valid", {31'b0, imem_req_valid}, 32'h1);
    check("t7_boot_addr",  imem_req_addr,            32'h40);

    // ---- 8: misaligned redirect --------------------------------------------
    do_reset();
    tick();
    redirect_to(32'h102);
`ifdef FETCH_MISALIGN_TRAP_EN
    check("t8_fault",      {31'b0, misalign_fault}, 32'h1);
    check("t8_no_req",     {31'b0, imem_req_valid}, 32'h0);
    tick();
    tick();
    check("t8_fault_hold", {31'b0, misalign_fault}, 32'h1);
    check("t8_still_none", {31'b0, imem_req_valid}, 32'h0);
    redirect_to(32'h80);
    check("t8_fault_clr",  {31'b0, misalign_fault}, 32'h0);
    check("t8_resume",     imem_req_addr,            32'h80);
    check("t8_resume_v",   {31'b0, imem_req_valid}, 32'h1);
`else
    check("t8_masked",     imem_req_addr,            32'h100);
    wait_valid("t8_wait");
    check("t8_pc",         pc_out,                   32'h100);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
